mc_controller: RTL

- Multicycle MIPS control unit: Moore FSM sequencer plus an embedded ALU decoder.
- Successor to the single-cycle combinational aludec. Adds per-state sequencing of datapath enables, an iterative multiply mode with a parametrised cycle count, and explicit handling of illegal opcodes.
- Sits between the instruction register (opcode/funct) and the multicycle datapath (PC, memory, regfile, ALU muxes).

---
 rtl/mc_controller.sv | 216 +++++++++++++++++++++
 1 files changed

// File: rtl/mc_controller.sv
// Multicycle MIPS control unit: Moore sequencer with an embedded ALU decoder,
// an iterative multiply state and illegal-instruction detection in DECODE.
module mc_controller #(
  parameter int n          = 32,
  parameter int MUL_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic       pcen,
  output logic       memwrite,
  output logic       irwrite,
  output logic       regwrite,
  output logic       iord,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic       regdst,
  output logic       memtoreg,
  output logic [1:0] pcsrc,
  output logic [2:0] alucontrol,
  output logic       busy,
  output logic       illegal
);

  if (MUL_CYCLES < 1 || MUL_CYCLES > 15 || n < 1) begin : g_param_check
    $error("mc_controller: MUL_CYCLES must be 1..15 and n positive");
  end

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] FN_MUL   = 6'b011000;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR, S_EXECUTE,
    S_MULEX, S_ALUWB, S_BRANCH, S_ADDIEX, S_ADDIWB, S_JUMP
  } state_t;

  state_t     r_state;
  state_t     w_next;
  logic [3:0] r_cnt;

  logic       w_op_legal, w_funct_legal, w_decode_bad;
  logic       w_pcwrite, w_branch, w_memwrite, w_irwrite, w_regwrite;
  logic       w_busy, w_illegal;
  logic [1:0] w_aluop;
  logic [2:0] w_alu_dec;

  // Opcode / funct legality, used by the DECODE branch and the illegal pulse
  always_comb begin
    w_op_legal    = 1'b0;
    w_funct_legal = 1'b0;
    case (opcode)
      OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J: w_op_legal = 1'b1;
      default:                                       w_op_legal = 1'b0;
    endcase
    case (funct)
      6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, FN_MUL:
        w_funct_legal = 1'b1;
      default: w_funct_legal = 1'b0;
    endcase
    w_decode_bad = !w_op_legal || ((opcode == OP_RTYPE) && !w_funct_legal);
  end

  // State register and multiply iteration counter
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_FETCH;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_EXECUTE)    r_cnt <= '0;
      else if (r_state == S_MULEX) r_cnt <= r_cnt + 4'd1;
    end
  end

  // Next-state selection
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_FETCH:   w_next = S_DECODE;
      S_DECODE: begin
        if (w_decode_bad) w_next = S_FETCH;
        else begin
          case (opcode)
            OP_LW, OP_SW: w_next = S_MEMADR;
            OP_RTYPE:     w_next = S_EXECUTE;
            OP_BEQ:       w_next = S_BRANCH;
            OP_ADDI:      w_next = S_ADDIEX;
            OP_J:         w_next = S_JUMP;
            default:      w_next = S_FETCH;
          endcase
        end
      end
      S_MEMADR:  w_next = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:   w_next = S_MEMWB;
      S_MEMWB:   w_next = S_FETCH;
      S_MEMWR:   w_next = S_FETCH;
      S_EXECUTE: w_next = (funct == FN_MUL) ? S_MULEX : S_ALUWB;
      S_MULEX:   w_next = (r_cnt == 4'(MUL_CYCLES - 1)) ? S_ALUWB : S_MULEX;
      S_ALUWB:   w_next = S_FETCH;
      S_BRANCH:  w_next = S_FETCH;
      S_ADDIEX:  w_next = S_ADDIWB;
      S_ADDIWB:  w_next = S_FETCH;
      S_JUMP:    w_next = S_FETCH;
      default:   w_next = S_FETCH;
    endcase
  end

  // Per-state datapath controls (Moore; illegal also qualifies on opcode/funct)
  always_comb begin
    w_pcwrite  = 1'b0;
    w_branch   = 1'b0;
    w_memwrite = 1'b0;
    w_irwrite  = 1'b0;
    w_regwrite = 1'b0;
    w_busy     = 1'b0;
    w_illegal  = 1'b0;
    w_aluop    = 2'b00;
    iord       = 1'b0;
    alusrca    = 1'b0;
    alusrcb    = 2'b00;
    regdst     = 1'b0;
    memtoreg   = 1'b0;
    pcsrc      = 2'b00;
    case (r_state)
      S_FETCH: begin
        alusrcb   = 2'b01;
        w_irwrite = 1'b1;
        w_pcwrite = 1'b1;
      end
      S_DECODE: begin
        alusrcb   = 2'b11;
        w_illegal = w_decode_bad;
      end
      S_MEMADR: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
      end
      S_MEMRD:  iord = 1'b1;
      S_MEMWB: begin
        memtoreg   = 1'b1;
        w_regwrite = 1'b1;
      end
      S_MEMWR: begin
        iord       = 1'b1;
        w_memwrite = 1'b1;
      end
      S_EXECUTE: begin
        alusrca = 1'b1;
        w_aluop = 2'b10;
      end
      S_MULEX: begin
        alusrca = 1'b1;
        w_busy  = 1'b1;
      end
      S_ALUWB: begin
        regdst     = 1'b1;
        w_regwrite = 1'b1;
      end
      S_BRANCH: begin
        alusrca  = 1'b1;
        w_aluop  = 2'b01;
        pcsrc    = 2'b01;
        w_branch = 1'b1;
      end
      S_ADDIEX: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
      end
      S_ADDIWB: w_regwrite = 1'b1;
      S_JUMP: begin
        pcsrc     = 2'b10;
        w_pcwrite = 1'b1;
      end
      default: ;
    endcase
  end

  // ALU decoder; unlisted funct codes fall back to add
  always_comb begin
    w_alu_dec = 3'b010;
    case (w_aluop)
      2'b00: w_alu_dec = 3'b010;
      2'b01: w_alu_dec = 3'b110;
      default: begin
        case (funct)
          6'b100000: w_alu_dec = 3'b010;
          6'b100010: w_alu_dec = 3'b110;
          6'b100100: w_alu_dec = 3'b000;
          6'b100101: w_alu_dec = 3'b001;
          6'b101010: w_alu_dec = 3'b111;
          FN_MUL:    w_alu_dec = 3'b011;
          default:   w_alu_dec = 3'b010;
        endcase
      end
    endcase
  end

  // Enables and status are squashed while reset is held so nothing commits
  always_comb begin
    alucontrol = (r_state == S_MULEX) ? 3'b011 : w_alu_dec;
    pcen       = !reset && (w_pcwrite || (w_branch && zero));
    memwrite   = !reset && w_memwrite;
    irwrite    = !reset && w_irwrite;
    regwrite   = !reset && w_regwrite;
    busy       = !reset && w_busy;
    illegal    = !reset && w_illegal;
  end

endmodule
